sport_fsgen_mc: RTL and testbench



---
 rtl/sport_pkg.sv | 17 +
 rtl/sport_sclk_div.sv | 45 ++++
 rtl/sport_fsgen_mc.sv | 147 ++++++++++++++
 tb/tb_sport_fsgen_mc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sport_pkg.sv
// Shared constants and helpers for the SPORT clock / frame-sync generator.
package sport_pkg;

  localparam logic [1:0] FSD_0 = 2'd0;
  localparam logic [1:0] FSD_1 = 2'd1;
  localparam logic [1:0] FSD_2 = 2'd2;
  localparam logic [1:0] FSD_3 = 2'd3;

  localparam logic FRM_NORMAL = 1'b0;
  localparam logic FRM_ALT    = 1'b1;

  // Width of a slot index for n slots; never narrower than one bit.
  function automatic int unsigned slot_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sport_sclk_div.sv
// SCLK divider: registered SCLK level plus one-cycle rise/fall strobes, no gated clocks.
module sport_sclk_div #(
  parameter int unsigned DIVW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [DIVW-1:0] sclkdiv,
  output logic            sclk_h,
  output logic            rise,
  output logic            fall,
  output logic            rise_nxt_c
);

  logic [DIVW-1:0] dcnt;
  logic            wrap_c;

  assign wrap_c     = en && (dcnt == sclkdiv);
  // Lets the frame logic update on the same edge that registers the rise strobe.
  assign rise_nxt_c = wrap_c && !sclk_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt   <= '0;
      sclk_h <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else if (!en) begin
      dcnt   <= '0;
      sclk_h <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else if (wrap_c) begin
      dcnt   <= '0;
      sclk_h <= !sclk_h;
      rise   <= !sclk_h;
      fall   <= sclk_h;
    end else begin
      dcnt   <= dcnt + DIVW'(1);
      rise   <= 1'b0;
      fall   <= 1'b0;
    end
  end

endmodule

// File: rtl/sport_fsgen_mc.sv
// SPORT clock and frame-sync generator with normal/alternate framing,
// 0-3 bit frame delay and multichannel slot tracking.
module sport_fsgen_mc
  import sport_pkg::*;
#(
  parameter int unsigned DIVW = 16,
  parameter int unsigned LENW = 5,
  parameter int unsigned NCH  = 8
) (
  input  logic                     DSPCLK,
  input  logic                     RST_,
  input  logic                     SP_EN,
  input  logic [DIVW-1:0]          SCLKDIV,
  input  logic [DIVW-1:0]          FSDIV,
  input  logic [LENW-1:0]          SLEN,
  input  logic [1:0]               FSD,
  input  logic                     AFS,
  input  logic                     MCE,
  input  logic [NCH-1:0]           SLOTMASK,
  input  logic                     INVSCLK,
  input  logic                     INVFS,
  output logic                     SCLKo,
  output logic                     SCLK_RISE,
  output logic                     SCLK_FALL,
  output logic                     FSo,
  output logic                     FS_SM,
  output logic [slot_w(NCH)-1:0]   SLOT,
  output logic                     SLOT_ACT,
  output logic                     SP_ACT
);

  localparam int unsigned     SW        = slot_w(NCH);
  localparam logic [SW-1:0]   SLOT_LAST = SW'(NCH - 1);

  logic            sclk_h;
  logic            tick_c;

  logic            started, started_n;
  logic [DIVW-1:0] fcnt, fcnt_n;
  logic [LENW-1:0] bcnt, bcnt_n;
  logic [SW-1:0]   slot_n;
  logic            sat, sat_n;
  logic            fs_h, fs_h_n;
  logic [2:0]      dly, dly_n;
  logic            fs_sm_n;
  logic            slot_act_n;
  logic            fst_c;
  logic            eow_c;

  always_ff @(posedge DSPCLK or negedge RST_) begin
    if (!RST_) SP_ACT <= 1'b0;
    else       SP_ACT <= SP_EN;
  end

  sport_sclk_div #(.DIVW(DIVW)) u_div (
    .clk        (DSPCLK),
    .rst_n      (RST_),
    .en         (SP_ACT),
    .sclkdiv    (SCLKDIV),
    .sclk_h     (sclk_h),
    .rise       (SCLK_RISE),
    .fall       (SCLK_FALL),
    .rise_nxt_c (tick_c)
  );

  // Pin levels follow the registered state; only the static polarity is combinational.
  assign SCLKo = sclk_h ^ INVSCLK;
  assign FSo   = fs_h ^ INVFS;

  // Frame, bit and slot sequencing; advances only on rise ticks.
  always_comb begin
    started_n  = started;
    fcnt_n     = fcnt;
    bcnt_n     = bcnt;
    slot_n     = SLOT;
    sat_n      = sat;
    fs_h_n     = fs_h;
    dly_n      = dly;
    fs_sm_n    = 1'b0;
    slot_act_n = 1'b0;
    fst_c      = !started || (fcnt == FSDIV);
    eow_c      = (bcnt == SLEN);

    if (!SP_ACT) begin
      started_n = 1'b0;
      fcnt_n    = '0;
      bcnt_n    = '0;
      slot_n    = '0;
      sat_n     = 1'b0;
      fs_h_n    = 1'b0;
      dly_n     = '0;
    end else if (tick_c) begin
      started_n = 1'b1;
      dly_n     = {dly[1:0], fst_c};
      unique case (FSD)
        FSD_0:   fs_sm_n = fst_c;
        FSD_1:   fs_sm_n = dly[0];
        FSD_2:   fs_sm_n = dly[1];
        default: fs_sm_n = dly[2];
      endcase

      if (fst_c) begin
        fcnt_n = '0;
        bcnt_n = '0;
        slot_n = '0;
        sat_n  = 1'b0;
        fs_h_n = 1'b1;
      end else begin
        fcnt_n = fcnt + DIVW'(1);
        bcnt_n = eow_c ? '0 : bcnt + LENW'(1);
        if (eow_c && !sat) begin
          if (SLOT == SLOT_LAST) sat_n  = 1'b1;
          else                   slot_n = SLOT + SW'(1);
        end
        fs_h_n = ((AFS == FRM_ALT) && !eow_c) ? fs_h : 1'b0;
      end
    end

    if (SP_ACT && started_n && !sat_n)
      slot_act_n = MCE ? SLOTMASK[slot_n] : 1'b1;
  end

  always_ff @(posedge DSPCLK or negedge RST_) begin
    if (!RST_) begin
      started  <= 1'b0;
      fcnt     <= '0;
      bcnt     <= '0;
      SLOT     <= '0;
      sat      <= 1'b0;
      fs_h     <= 1'b0;
      dly      <= '0;
      FS_SM    <= 1'b0;
      SLOT_ACT <= 1'b0;
    end else begin
      started  <= started_n;
      fcnt     <= fcnt_n;
      bcnt     <= bcnt_n;
      SLOT     <= slot_n;
      sat      <= sat_n;
      fs_h     <= fs_h_n;
      dly      <= dly_n;
      FS_SM    <= fs_sm_n;
      SLOT_ACT <= slot_act_n;
    end
  end

endmodule

// File: tb/tb_sport_fsgen_mc.sv
// Scoreboard bench for sport_fsgen_mc: expected per-rise-tick framing is
// derived from the configuration and checked as each SCLK_RISE appears.
module tb_sport_fsgen_mc;

  logic        DSPCLK = 1'b0;
  logic        RST_;
  logic        SP_EN;
  logic [15:0] SCLKDIV;
  logic [15:0] FSDIV;
  logic [4:0]  SLEN;
  logic [1:0]  FSD;
  logic        AFS;
  logic        MCE;
  logic [7:0]  SLOTMASK;
  logic        INVSCLK;
  logic        INVFS;
  logic        SCLKo;
  logic        SCLK_RISE;
  logic        SCLK_FALL;
  logic        FSo;
  logic        FS_SM;
  logic [2:0]  SLOT;
  logic        SLOT_ACT;
  logic        SP_ACT;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       fs;
    logic       fs_sm;
    logic [2:0] slot;
    logic       slot_act;
  } exp_t;

  exp_t exp_q[$];

  sport_fsgen_mc #(.DIVW(16), .LENW(5), .NCH(8)) dut (
    .DSPCLK    (DSPCLK),
    .RST_      (RST_),
    .SP_EN     (SP_EN),
    .SCLKDIV   (SCLKDIV),
    .FSDIV     (FSDIV),
    .SLEN      (SLEN),
    .FSD       (FSD),
    .AFS       (AFS),
    .MCE       (MCE),
    .SLOTMASK  (SLOTMASK),
    .INVSCLK   (INVSCLK),
    .INVFS     (INVFS),
    .SCLKo     (SCLKo),
    .SCLK_RISE (SCLK_RISE),
    .SCLK_FALL (SCLK_FALL),
    .FSo       (FSo),
    .FS_SM     (FS_SM),
    .SLOT      (SLOT),
    .SLOT_ACT  (SLOT_ACT),
    .SP_ACT    (SP_ACT)
  );

  always #5 DSPCLK = ~DSPCLK;

  // Expected state after rise tick k, with tick 0 the first frame start after enable.
  task automatic push_expected(input int n);
    int p, w, kf, wi;
    exp_t e;
    p = int'(FSDIV) + 1;
    w = int'(SLEN) + 1;
    for (int k = 0; k < n; k++) begin
      kf = k % p;
      wi = kf / w;
      e.fs       = AFS ? (kf < w) : (kf == 0);
      e.fs_sm    = (k >= int'(FSD)) && (((k - int'(FSD)) % p) == 0);
      e.slot     = (wi > 7) ? 3'd7 : 3'(wi);
      e.slot_act = (wi > 7) ? 1'b0 : (MCE ? SLOTMASK[wi] : 1'b1);
      exp_q.push_back(e);
    end
  endtask

  task automatic enable_port();
    @(negedge DSPCLK);
    SP_EN = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge DSPCLK);
    SP_EN = 1'b1;
  endtask

  // Pops one expectation per SCLK_RISE; called right after enable_port.
  task automatic drain(input int n);
    int   cnt, since, budget, gap;
    bit   first;
    exp_t e;
    cnt = 0; since = 0; first = 1'b1;
    budget = (n + 2) * 2 * (int'(SCLKDIV) + 1) + 20;
    while (cnt < n && budget > 0) begin
      @(negedge DSPCLK);
      since++;
      budget--;
      if (first && since == 1) begin
        n_cmp++;
        if (SP_ACT !== 1'b1) begin n_bad++; $display("FAIL sp_act_latency: got %b expected 1", SP_ACT); end
      end
      if (SCLK_FALL === 1'b1) begin
        n_cmp++;
        if (SCLKo !== INVSCLK) begin n_bad++; $display("FAIL sclk_fall_level: got %b expected %b", SCLKo, INVSCLK); end
      end
      if (SCLK_RISE === 1'b1) begin
        e   = exp_q.pop_front();
        gap = first ? int'(SCLKDIV) + 2 : 2 * (int'(SCLKDIV) + 1);
        n_cmp += 6;
        if (since !== gap) begin n_bad++; $display("FAIL rise_gap tick %0d: got %0d cycles expected %0d", cnt, since, gap); end
        if (SCLKo !== ~INVSCLK) begin n_bad++; $display("FAIL sclk_rise_level tick %0d: got %b expected %b", cnt, SCLKo, ~INVSCLK); end
        if (FSo !== (e.fs ^ INVFS)) begin n_bad++; $display("FAIL fso tick %0d: got %b expected %b", cnt, FSo, e.fs ^ INVFS); end
        if (FS_SM !== e.fs_sm) begin n_bad++; $display("FAIL fs_sm tick %0d: got %b expected %b", cnt, FS_SM, e.fs_sm); end
        if (SLOT !== e.slot) begin n_bad++; $display("FAIL slot tick %0d: got %0d expected %0d", cnt, SLOT, e.slot); end
        if (SLOT_ACT !== e.slot_act) begin n_bad++; $display("FAIL slot_act tick %0d: got %b expected %b", cnt, SLOT_ACT, e.slot_act); end
        since = 0;
        first = 1'b0;
        cnt++;
      end else if (FS_SM === 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL fs_sm_stray: got 1 expected 0 outside a rise");
      end
    end
    if (cnt < n) begin
      n_cmp++; n_bad++;
      $display("FAIL rise_timeout: got %0d rises expected %0d", cnt, n);
      exp_q.delete();
    end
  endtask

  task automatic set_cfg(input int sdiv, input int fdiv, input int slen,
                         input int fsd, input bit afs, input bit mce, input logic [7:0] mask);
    SCLKDIV = 16'(sdiv); FSDIV = 16'(fdiv); SLEN = 5'(slen);
    FSD = 2'(fsd); AFS = afs; MCE = mce; SLOTMASK = mask;
  endtask

  task automatic test_reset();
    RST_ = 1'b0; SP_EN = 1'b1; INVSCLK = 1'b1; INVFS = 1'b1;
    set_cfg(2, 15, 7, 0, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge DSPCLK);
    n_cmp += 4;
    if (SCLKo !== 1'b1) begin n_bad++; $display("FAIL reset_sclko: got %b expected 1", SCLKo); end
    if (FSo !== 1'b1) begin n_bad++; $display("FAIL reset_fso: got %b expected 1", FSo); end
    if ({SCLK_RISE, SCLK_FALL, FS_SM, SLOT_ACT, SP_ACT} !== 5'b0) begin
      n_bad++; $display("FAIL reset_strobes: got %b expected 00000", {SCLK_RISE, SCLK_FALL, FS_SM, SLOT_ACT, SP_ACT});
    end
    if (SLOT !== 3'd0) begin n_bad++; $display("FAIL reset_slot: got %0d expected 0", SLOT); end
    SP_EN = 1'b0; INVSCLK = 1'b0; INVFS = 1'b0;
    @(negedge DSPCLK);
    RST_ = 1'b1;
  endtask

  task automatic test_normal();
    set_cfg(2, 15, 7, 0, 1'b0, 1'b0, 8'h00);
    enable_port(); push_expected(40); drain(40);
  endtask

  task automatic test_alt();
    set_cfg(2, 15, 7, 0, 1'b1, 1'b0, 8'h00);
    enable_port(); push_expected(40); drain(40);
    set_cfg(2, 3, 7, 0, 1'b1, 1'b0, 8'h00);
    enable_port(); push_expected(20); drain(20);
  endtask

  task automatic test_fsd_sweep();
    for (int d = 0; d < 4; d++) begin
      set_cfg(1, 7, 3, d, 1'b0, 1'b0, 8'h00);
      enable_port(); push_expected(20); drain(20);
    end
  endtask

  task automatic test_multichannel();
    set_cfg(0, 39, 3, 0, 1'b0, 1'b1, 8'hA5);
    enable_port(); push_expected(90); drain(90);
  endtask

  task automatic test_invert();
    INVSCLK = 1'b1; INVFS = 1'b1;
    set_cfg(0, 7, 7, 1, 1'b0, 1'b0, 8'h00);
    enable_port(); push_expected(16); drain(16);
    INVSCLK = 1'b0; INVFS = 1'b0;
  endtask

  task automatic test_disable();
    int strobes;
    set_cfg(1, 7, 3, 3, 1'b1, 1'b0, 8'h00);
    enable_port(); push_expected(2); drain(2);
    SP_EN = 1'b0;
    repeat (2) @(negedge DSPCLK);
    n_cmp += 4;
    if (SCLKo !== INVSCLK) begin n_bad++; $display("FAIL dis_sclko: got %b expected %b", SCLKo, INVSCLK); end
    if (FSo !== INVFS) begin n_bad++; $display("FAIL dis_fso: got %b expected %b", FSo, INVFS); end
    if (SLOT !== 3'd0) begin n_bad++; $display("FAIL dis_slot: got %0d expected 0", SLOT); end
    if ({SP_ACT, SLOT_ACT} !== 2'b00) begin n_bad++; $display("FAIL dis_act: got %b expected 00", {SP_ACT, SLOT_ACT}); end
    strobes = 0;
    repeat (30) begin
      @(negedge DSPCLK);
      if (SCLK_RISE || SCLK_FALL || FS_SM) strobes++;
    end
    n_cmp++;
    if (strobes !== 0) begin n_bad++; $display("FAIL dis_strobes: got %0d expected 0", strobes); end
    enable_port(); push_expected(10); drain(10);
  endtask

  task automatic test_async_reset();
    set_cfg(2, 15, 7, 0, 1'b0, 1'b0, 8'h00);
    enable_port(); push_expected(3); drain(3);
    #2 RST_ = 1'b0;
    #1;
    n_cmp += 4;
    if (SCLKo !== INVSCLK) begin n_bad++; $display("FAIL arst_sclko: got %b expected %b", SCLKo, INVSCLK); end
    if (FSo !== INVFS) begin n_bad++; $display("FAIL arst_fso: got %b expected %b", FSo, INVFS); end
    if (SLOT !== 3'd0) begin n_bad++; $display("FAIL arst_slot: got %0d expected 0", SLOT); end
    if ({SCLK_RISE, SCLK_FALL, FS_SM, SLOT_ACT, SP_ACT} !== 5'b0) begin
      n_bad++; $display("FAIL arst_outs: got %b expected 00000", {SCLK_RISE, SCLK_FALL, FS_SM, SLOT_ACT, SP_ACT});
    end
    @(negedge DSPCLK);
    SP_EN = 1'b0;
    @(negedge DSPCLK);
    RST_ = 1'b1;
    enable_port(); push_expected(8); drain(8);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_alt();
    test_fsd_sweep();
    test_multichannel();
    test_invert();
    test_disable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
